// File: rtl/dmem_axi_master.sv
// MEM-stage data access unit: turns each load/store from the EX/MEM register into
// one single-beat AXI4 transaction and stalls the pipeline until it completes.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no access in flight; a request stalls and starts a transaction
// S_RD_ADDR | ARVALID held until ARREADY
// S_RD_DATA | RREADY high, waiting for the read beat
// S_WR_REQ  | AW and W offered together, each drops after its own handshake
// S_WR_RESP | BREADY high, waiting for the write response
// S_DONE    | one unstalled cycle so the held EX/MEM request is not re-issued
module dmem_axi_master #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] MASTER_ID = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_memread,
  input  logic              mem_memwrite,
  input  logic              ls_word,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic              d_stall,
  output logic              bus_err,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ID_W-1:0]   AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [3:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [ID_W-1:0]   BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [2:0]        size_q;
  logic              aw_done, w_done;
  logic [DATA_W-1:0] store_data;
  logic [3:0]        store_strb;
  logic              unused_inputs;

  // Only one transaction is ever outstanding, so IDs and RLAST carry no information.
  assign unused_inputs = ^{RID, BID, RLAST};

  always_comb begin
    store_data = wdata_in;
    store_strb = 4'b1111;
    if (!ls_word) begin
      store_data = DATA_W'(wdata_in[7:0]) << {addr[1:0], 3'b000};
      store_strb = 4'b0001 << addr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (mem_memwrite)     state_nxt = S_WR_REQ;
        else if (mem_memread) state_nxt = S_RD_ADDR;
      end
      S_RD_ADDR: if (ARREADY) state_nxt = S_RD_DATA;
      S_RD_DATA: if (RVALID)  state_nxt = S_DONE;
      S_WR_REQ:  if ((aw_done || AWREADY) && (w_done || WREADY)) state_nxt = S_WR_RESP;
      S_WR_RESP: if (BVALID)  state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    BREADY  = 1'b0;
    d_stall = 1'b1;
    case (state)
      S_IDLE:    d_stall = mem_memread | mem_memwrite;
      S_RD_ADDR: ARVALID = 1'b1;
      S_RD_DATA: RREADY  = 1'b1;
      S_WR_REQ: begin
        AWVALID = !aw_done;
        WVALID  = !w_done;
      end
      S_WR_RESP: BREADY  = 1'b1;
      S_DONE:    d_stall = 1'b0;
      default:   d_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      size_q    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_out <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (state == S_IDLE && (mem_memwrite || mem_memread)) begin
        addr_q  <= addr;
        size_q  <= ls_word ? 3'b010 : 3'b000;
        wdata_q <= store_data;
        wstrb_q <= store_strb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (AWVALID && AWREADY) aw_done <= 1'b1;
      if (WVALID && WREADY)   w_done  <= 1'b1;
      if (state == S_RD_DATA && RVALID) begin
        rdata_out <= RDATA;
        if (RRESP != 2'b00) bus_err <= 1'b1;
      end
      if (state == S_WR_RESP && BVALID && BRESP != 2'b00) bus_err <= 1'b1;
    end
  end

  assign ARID    = MASTER_ID;
  assign AWID    = MASTER_ID;
  assign ARLEN   = 8'd0;
  assign AWLEN   = 8'd0;
  assign ARBURST = 2'b01;
  assign AWBURST = 2'b01;
  assign WLAST   = 1'b1;
  assign ARADDR  = addr_q;
  assign AWADDR  = addr_q;
  assign ARSIZE  = size_q;
  assign AWSIZE  = size_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;

endmodule

// File: tb/tb_dmem_axi_master.sv
// Directed bench for dmem_axi_master with a delay-configurable AXI slave model.
module tb_dmem_axi_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_memread, mem_memwrite, ls_word;
  logic [31:0] addr, wdata_in, rdata_out;
  logic        d_stall, bus_err;
  logic [3:0]  ARID, AWID, RID, BID;
  logic [31:0] ARADDR, AWADDR, RDATA, WDATA;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [3:0]  WSTRB;

  int checks = 0;
  int failures = 0;

  // slave configuration and bookkeeping
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  int ar_age = 0, r_age = 0, aw_age = 0, w_age = 0, b_age = 0;
  int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
  int wv_cyc = 0, awv_cyc = 0, aw_only_cyc = 0, arv_cyc = 0;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [3:0]  cap_wstrb;

  dmem_axi_master dut (
    .clk(clk), .rst(rst), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .ls_word(ls_word), .addr(addr), .wdata_in(wdata_in), .rdata_out(rdata_out),
    .d_stall(d_stall), .bus_err(bus_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  assign ARREADY = ARVALID && (ar_age >= ar_delay);
  assign AWREADY = AWVALID && (aw_age >= aw_delay);
  assign WREADY  = WVALID  && (w_age  >= w_delay);
  assign RVALID  = RREADY  && (r_age  >= r_delay);
  assign BVALID  = BREADY  && (b_age  >= b_delay);
  assign RDATA   = rdata_cfg;
  assign RRESP   = rresp_cfg;
  assign BRESP   = bresp_cfg;
  assign RID     = 4'd1;
  assign BID     = 4'd1;
  assign RLAST   = 1'b1;

  always @(posedge clk) begin
    ar_age <= (ARVALID && !ARREADY) ? ar_age + 1 : 0;
    aw_age <= (AWVALID && !AWREADY) ? aw_age + 1 : 0;
    w_age  <= (WVALID  && !WREADY)  ? w_age + 1  : 0;
    r_age  <= (RREADY  && !RVALID)  ? r_age + 1  : 0;
    b_age  <= (BREADY  && !BVALID)  ? b_age + 1  : 0;
    if (ARVALID && ARREADY) begin
      ar_hs <= ar_hs + 1; cap_araddr <= ARADDR; cap_arsize <= ARSIZE;
    end
    if (AWVALID && AWREADY) begin
      aw_hs <= aw_hs + 1; cap_awaddr <= AWADDR; cap_awsize <= AWSIZE;
    end
    if (WVALID && WREADY) begin
      w_hs <= w_hs + 1; cap_wdata <= WDATA; cap_wstrb <= WSTRB;
    end
    if (RVALID && RREADY) r_hs <= r_hs + 1;
    if (BVALID && BREADY) b_hs <= b_hs + 1;
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  // Runs until d_stall drops (the DONE cycle), tallying stall and valid cycles.
  task automatic run_access(output int stalls);
    int n;
    stalls = 0; n = 0;
    wv_cyc = 0; awv_cyc = 0; aw_only_cyc = 0; arv_cyc = 0;
    #1;
    while (d_stall === 1'b1 && n < 100) begin
      stalls++;
      if (WVALID) wv_cyc++;
      if (AWVALID) awv_cyc++;
      if (AWVALID && !WVALID) aw_only_cyc++;
      if (ARVALID) arv_cyc++;
      cycle();
      n++;
    end
    if (n >= 100) begin
      failures++;
      $display("FAIL access_timeout got=stall_stuck exp=done_within_100");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_memread = 0; mem_memwrite = 0; ls_word = 1; addr = 0; wdata_in = 0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    checks++;
    if ({ARVALID, AWVALID, WVALID, RREADY, BREADY} !== 5'b0) begin
      failures++; $display("FAIL reset_valids got=%b exp=00000", {ARVALID, AWVALID, WVALID, RREADY, BREADY});
    end
    checks++;
    if ({d_stall, bus_err} !== 2'b00) begin
      failures++; $display("FAIL reset_stall_err got=%b exp=00", {d_stall, bus_err});
    end
    checks++;
    if (rdata_out !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0", rdata_out);
    end
    checks++;
    if ({ARLEN, AWLEN, ARBURST, AWBURST, WLAST, ARID, AWID} !== {8'd0, 8'd0, 2'b01, 2'b01, 1'b1, 4'd1, 4'd1}) begin
      failures++; $display("FAIL const_outputs got=%h", {ARLEN, AWLEN, ARBURST, AWBURST, WLAST, ARID, AWID});
    end
  endtask

  task automatic test_word_load();
    int st, ar0;
    ar0 = ar_hs;
    ar_delay = 2; r_delay = 2; rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b00;
    addr = 32'h0000_0104; ls_word = 1; mem_memread = 1;
    run_access(st);
    mem_memread = 0;
    checks++;
    if (st !== 7) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=7", st); end
    checks++;
    if (rdata_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", rdata_out); end
    checks++;
    if ({cap_araddr, cap_arsize} !== {32'h104, 3'd2}) begin
      failures++; $display("FAIL load_ar got=%h/%0d exp=104/2", cap_araddr, cap_arsize);
    end
    cycle(); cycle();
    checks++;
    if ({d_stall, ARVALID} !== 2'b00 || ar_hs - ar0 !== 1) begin
      failures++; $display("FAIL load_single got=stall%b ar_hs%0d exp=0/1", d_stall, ar_hs - ar0);
    end
    ar_delay = 0; r_delay = 0;
  endtask

  task automatic test_byte_store();
    int st;
    aw_delay = 0; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
    addr = 32'h0000_0203; wdata_in = 32'h1234_56AB; ls_word = 0; mem_memwrite = 1;
    run_access(st);
    mem_memwrite = 0;
    checks++;
    if (st !== 3) begin failures++; $display("FAIL store_stall_cycles got=%0d exp=3", st); end
    checks++;
    if ({cap_awaddr, cap_awsize} !== {32'h203, 3'd0}) begin
      failures++; $display("FAIL store_aw got=%h/%0d exp=203/0", cap_awaddr, cap_awsize);
    end
    checks++;
    if ({cap_wstrb, cap_wdata} !== {4'b1000, 32'hAB00_0000}) begin
      failures++; $display("FAIL store_w got=%b/%h exp=1000/ab000000", cap_wstrb, cap_wdata);
    end
    checks++;
    if (bus_err !== 1'b0) begin failures++; $display("FAIL store_okay_err got=%b exp=0", bus_err); end
    cycle();
    addr = 32'h0000_0011; wdata_in = 32'hFFFF_FF5C; mem_memwrite = 1;
    run_access(st);
    mem_memwrite = 0;
    checks++;
    if ({cap_wstrb, cap_wdata} !== {4'b0010, 32'h0000_5C00}) begin
      failures++; $display("FAIL store_lane1 got=%b/%h exp=0010/00005c00", cap_wstrb, cap_wdata);
    end
    cycle();
  endtask

  task automatic test_write_order();
    int st, aw0, w0, b0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    aw_delay = 4; w_delay = 1; b_delay = 0;
    addr = 32'h0000_0300; wdata_in = 32'hCAFE_F00D; ls_word = 1; mem_memwrite = 1;
    run_access(st);
    mem_memwrite = 0;
    checks++;
    if (st !== 7) begin failures++; $display("FAIL order_stall_cycles got=%0d exp=7", st); end
    checks++;
    if ({wv_cyc, awv_cyc, aw_only_cyc} !== {32'd2, 32'd5, 32'd3}) begin
      failures++; $display("FAIL order_valid_cycles got=w%0d aw%0d awonly%0d exp=2/5/3", wv_cyc, awv_cyc, aw_only_cyc);
    end
    cycle(); cycle();
    checks++;
    if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1 || b_hs - b0 !== 1) begin
      failures++; $display("FAIL order_handshakes got=aw%0d w%0d b%0d exp=1/1/1", aw_hs - aw0, w_hs - w0, b_hs - b0);
    end
    checks++;
    if ({cap_wstrb, cap_wdata} !== {4'b1111, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL order_wdata got=%b/%h exp=1111/cafef00d", cap_wstrb, cap_wdata);
    end
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_simultaneous();
    int st, aw0, ar0;
    aw0 = aw_hs; ar0 = ar_hs;
    addr = 32'h0000_0400; wdata_in = 32'h0BAD_F00D; ls_word = 1;
    mem_memread = 1; mem_memwrite = 1;
    run_access(st);
    mem_memread = 0; mem_memwrite = 0;
    cycle(); cycle();
    checks++;
    if (arv_cyc !== 0 || ar_hs - ar0 !== 0 || aw_hs - aw0 !== 1) begin
      failures++; $display("FAIL simul_write_wins got=arv%0d ar%0d aw%0d exp=0/0/1", arv_cyc, ar_hs - ar0, aw_hs - aw0);
    end
  endtask

  task automatic test_error_reset();
    int st, n;
    rdata_cfg = 32'h1111_2222; rresp_cfg = 2'b10;
    addr = 32'h0000_0500; ls_word = 1; mem_memread = 1;
    run_access(st);
    mem_memread = 0;
    rresp_cfg = 2'b00;
    checks++;
    if ({bus_err, rdata_out} !== {1'b1, 32'h1111_2222}) begin
      failures++; $display("FAIL rresp_err got=%b/%h exp=1/11112222", bus_err, rdata_out);
    end
    cycle();
    addr = 32'h0000_0504; wdata_in = 32'h7777_8888; mem_memwrite = 1;
    run_access(st);
    mem_memwrite = 0;
    checks++;
    if ({bus_err, rdata_out} !== {1'b1, 32'h1111_2222}) begin
      failures++; $display("FAIL err_sticky_store got=%b/%h exp=1/11112222", bus_err, rdata_out);
    end
    cycle();
    rdata_cfg = 32'h3333_4444; mem_memread = 1;
    run_access(st);
    mem_memread = 0;
    checks++;
    if ({bus_err, rdata_out} !== {1'b1, 32'h3333_4444}) begin
      failures++; $display("FAIL err_sticky_load got=%b/%h exp=1/33334444", bus_err, rdata_out);
    end
    cycle();
    r_delay = 10; mem_memread = 1;
    n = 0;
    while (RREADY !== 1'b1 && n < 20) begin cycle(); n++; end
    checks++;
    if (RREADY !== 1'b1) begin failures++; $display("FAIL reach_rd_data got=%b exp=1", RREADY); end
    rst = 1'b1; mem_memread = 0;
    cycle();
    checks++;
    if ({ARVALID, AWVALID, WVALID, RREADY, BREADY, d_stall, bus_err} !== 7'b0 || rdata_out !== 32'h0) begin
      failures++; $display("FAIL midflight_reset got=%b/%h exp=0000000/0",
                           {ARVALID, AWVALID, WVALID, RREADY, BREADY, d_stall, bus_err}, rdata_out);
    end
    rst = 1'b0; r_delay = 0;
    cycle(); cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    int aw0, ar0;
    aw0 = aw_hs; ar0 = ar_hs;
    rdata_cfg = 32'h5A5A_0100;
    addr = 32'h0000_0100; wdata_in = 32'h55AA_55AA; ls_word = 1; mem_memwrite = 1;
    pat = 8'h0;
    #1;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[6:0], d_stall};
      if (i == 3) begin mem_memwrite = 0; mem_memread = 1; end
      if (i == 7) mem_memread = 0;
      cycle();
      #1;
    end
    cycle();
    checks++;
    if (pat !== 8'b1110_1110) begin failures++; $display("FAIL b2b_stall_pattern got=%b exp=11101110", pat); end
    checks++;
    if (aw_hs - aw0 !== 1 || ar_hs - ar0 !== 1) begin
      failures++; $display("FAIL b2b_handshakes got=aw%0d ar%0d exp=1/1", aw_hs - aw0, ar_hs - ar0);
    end
    checks++;
    if (rdata_out !== 32'h5A5A_0100) begin failures++; $display("FAIL b2b_rdata got=%h exp=5a5a0100", rdata_out); end
  endtask

  initial begin
    rst = 1'b1; mem_memread = 0; mem_memwrite = 0; ls_word = 1; addr = 0; wdata_in = 0;
    test_reset();
    test_word_load();
    test_byte_store();
    test_write_order();
    test_simultaneous();
    test_error_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_axi_master.md
Name: dmem_axi_master

Overview:
- Data-side memory access unit in the MEM stage. Consumes the EX/MEM pipeline register outputs: address, store data, memread/memwrite and ls_word.
- Converts each access into a single-beat AXI4 read or write transaction.
- Drives d_stall back to the pipeline while a transaction is in flight. Returns load data to MEM/WB.

Parameters:
- ADDR_W, 32, AXI address and pipeline address width.
- DATA_W, 32, AXI data width and pipeline data width.
- ID_W, 4, AXI ID width.
- MASTER_ID, 4'd1, constant driven on ARID/AWID.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_memread  in  1  load request from the EX/MEM register.
- mem_memwrite  in  1  store request from the EX/MEM register.
- ls_word  in  1  1 = word access, 0 = byte access.
- addr  in  ADDR_W  access address (EX/MEM result).
- wdata_in  in  DATA_W  store data (EX/MEM data2_out).
- rdata_out  out  DATA_W  raw 32-bit load word.
- d_stall  out  1  freezes the pipeline, including EX/MEM.
- bus_err  out  1  sticky; set by any non-OKAY response.
- Read address channel: ARID out ID_W, ARADDR out ADDR_W, ARLEN out 8, ARSIZE out 3, ARBURST out 2, ARVALID out 1, ARREADY in 1.
- Read data channel: RID in ID_W, RDATA in DATA_W, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1.
- Write address channel: AWID out ID_W, AWADDR out ADDR_W, AWLEN out 8, AWSIZE out 3, AWBURST out 2, AWVALID out 1, AWREADY in 1.
- Write data channel: WDATA out DATA_W, WSTRB out 4, WLAST out 1, WVALID out 1, WREADY in 1.
- Write response channel: BID in ID_W, BRESP in 2, BVALID in 1, BREADY out 1.

Behaviour:
- Reset (synchronous):
  - State returns to IDLE.
  - All VALID/READY outputs go to 0.
  - rdata_out and bus_err go to 0.
  - Any transaction in flight is abandoned; the interconnect shares the reset.
- Constant outputs: ARLEN=AWLEN=0; ARBURST=AWBURST=2'b01; WLAST=1; ARID=AWID=MASTER_ID.
- ARSIZE/AWSIZE: 3'b010 when ls_word=1, 3'b000 when ls_word=0.
- Address: ARADDR/AWADDR = addr, registered at transaction start.
- Word store: WSTRB=4'b1111, WDATA=wdata_in.
- Byte store, lane = addr[1:0]:
  - WSTRB = 4'b0001 << lane.
  - WDATA = wdata_in[7:0] << (8*lane).
  - Other bytes are 0.
- States:
  - IDLE:
    - d_stall = mem_memread | mem_memwrite (combinational).
    - If mem_memwrite=1: latch addr, data and strobe; go to WR_REQ. mem_memwrite wins if both requests are set.
    - Else if mem_memread=1: latch addr; go to RD_ADDR.
  - RD_ADDR:
    - ARVALID=1, held until ARREADY is sampled high.
    - Then go to RD_DATA.
    - d_stall=1.
  - RD_DATA:
    - RREADY=1.
    - On RVALID: rdata_out<=RDATA; if RRESP!=0, bus_err<=1; go to DONE.
    - d_stall=1.
  - WR_REQ:
    - AWVALID and WVALID are both asserted on entry.
    - Each valid drops independently after its own handshake.
    - Either channel may complete first, or both in the same cycle.
    - When both are done, go to WR_RESP.
    - d_stall=1.
  - WR_RESP:
    - BREADY=1.
    - On BVALID: if BRESP!=0, bus_err<=1; go to DONE.
    - d_stall=1.
  - DONE:
    - d_stall=0 for exactly one cycle, so the pipeline advances past the completed access.
    - Requests are ignored in this cycle, which prevents re-issue of the held EX/MEM request.
    - Go to IDLE.
- Minimum access latency with zero-wait slaves:
  - Read: IDLE → RD_ADDR → RD_DATA → DONE = 3 stall cycles.
  - Write: IDLE → WR_REQ → WR_RESP → DONE = 3 stall cycles.
- rdata_out holds its value until the next read completes. Stores do not change it.
- VALID never drops before its handshake (AXI rule). Address, data and strobe stay stable while VALID is high.
- RID, BID and RLAST are ignored; only one transaction is outstanding at any time.
- With no request, d_stall=0 and all AXI outputs are idle.

Test Plan:
- Word load, addr=0x0000_0104: ARREADY high 2 cycles after ARVALID, RVALID 3 cycles later with RDATA=0xDEAD_BEEF → ARADDR=0x104, ARSIZE=2; d_stall high 7 cycles, then low 1 cycle; rdata_out=0xDEAD_BEEF.
- Byte store, addr=0x0000_0203, wdata_in=0x1234_56AB → AWSIZE=0, WSTRB=4'b1000, WDATA=0xAB00_0000; BRESP=OKAY → bus_err=0.
- Write channel ordering: WREADY 1 cycle and AWREADY 4 cycles after entering WR_REQ → WVALID drops after its handshake, AWVALID stays high until its handshake; one B handshake; single transaction only.
- Simultaneous mem_memread=1 and mem_memwrite=1 → only the AW/W write is issued, ARVALID stays 0.
- Error and reset: RRESP=2'b10 → bus_err=1 and stays 1 through later OKAY accesses. Then rst asserted during RD_DATA → next cycle all valids=0, d_stall=0, bus_err=0, rdata_out=0.
- Back-to-back: store then load at 0x100 with zero-wait slave → d_stall pattern 1,1,1,0,1,1,1,0; exactly one AW and one AR handshake.
